// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-layer datapath: FSM state encoding and
// signed saturation bounds as constant functions of width.
package snn_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ACC = 1'b0;
  localparam state_t OUT = 1'b1;

  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/spike_accumulator_sat_add.sv
// Combinational OUT_WIDTH signed add of accumulator and extended addend.
// Clamps when SPIKE_ACC_SATURATE_EN is defined, otherwise wraps (clamp = 0).
module sat_add
  import snn_pkg::*;
#(
  parameter int OUT_WIDTH = 12
) (
  input  logic signed [OUT_WIDTH-1:0] acc,
  input  logic signed [OUT_WIDTH-1:0] addend,
  output logic signed [OUT_WIDTH-1:0] result,
  output logic                        clamp
);

`ifdef SPIKE_ACC_SATURATE_EN
  localparam logic signed [31:0] MAX_V = sat_max(OUT_WIDTH);
  localparam logic signed [31:0] MIN_V = sat_min(OUT_WIDTH);

  // One guard bit makes the true sum of two OUT_WIDTH operands exact.
  logic signed [OUT_WIDTH:0] sum;
  logic signed [31:0]        sum_wide;

  assign sum      = {acc[OUT_WIDTH-1], acc} + {addend[OUT_WIDTH-1], addend};
  assign sum_wide = 32'(sum);

  // NOTE: every output gets a default first so always_comb never infers a latch.
  always_comb begin
    result = sum[OUT_WIDTH-1:0];
    clamp  = 1'b0;
    if (sum_wide > MAX_V) begin
      result = MAX_V[OUT_WIDTH-1:0];
      clamp  = 1'b1;
    end else if (sum_wide < MIN_V) begin
      result = MIN_V[OUT_WIDTH-1:0];
      clamp  = 1'b1;
    end
  end
`else
  assign result = acc + addend;
  assign clamp  = 1'b0;
`endif

endmodule

// File: rtl/spike_accumulator.sv
// Frame accumulator of spike-gated signed weights with valid/ready on both sides.
// Optional clamping and sticky out_sat under SPIKE_ACC_SATURATE_EN.
module spike_accumulator
  import snn_pkg::*;
#(
  parameter int INP_WIDTH = 8,
  parameter int OUT_WIDTH = 12,
  parameter int NUM_IN    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [INP_WIDTH-1:0] in_data,
  input  logic                        in_spike,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat
);

  localparam int                 CNT_W = $clog2(NUM_IN);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(NUM_IN - 1);

  state_t                        state;
  logic signed [OUT_WIDTH-1:0]   acc;
  logic        [CNT_W-1:0]       cnt;
  logic                          sticky;
  logic signed [OUT_WIDTH-1:0]   addend;
  logic signed [OUT_WIDTH-1:0]   next_acc;
  logic                          clamp;
  logic                          accept;

  assign addend = in_spike ? {{(OUT_WIDTH-INP_WIDTH){in_data[INP_WIDTH-1]}}, in_data}
                           : '0;

  sat_add #(.OUT_WIDTH(OUT_WIDTH)) u_sat_add (
    .acc    (acc),
    .addend (addend),
    .result (next_acc),
    .clamp  (clamp)
  );

  // Handshake flags decode the state register only; rst gates in_ready low.
  assign in_ready  = (state == ACC) && !rst;
  assign out_valid = (state == OUT);
  assign accept    = in_valid && (state == ACC);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACC;
      acc      <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (cnt == LAST) begin
              out_data <= next_acc;
              out_sat  <= sticky | clamp;
              acc      <= '0;
              cnt      <= '0;
              sticky   <= 1'b0;
              state    <= OUT;
            end else begin
              acc    <= next_acc;
              cnt    <= cnt + 1'b1;
              sticky <= sticky | clamp;
            end
          end
        end
        default: begin
          if (out_ready) state <= ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_accumulator.sv
// Bench for spike_accumulator: a 12-bit and a 9-bit instance (NUM_IN=4) driven
// in lockstep, checked against a per-beat arithmetic reference model.
module tb_spike_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_spike;
  logic       out_ready;
  logic [7:0] in_data;

  logic              in_ready_a, out_valid_a, out_sat_a;
  logic signed [11:0] out_data_a;
  logic              in_ready_b, out_valid_b, out_sat_b;
  logic signed [8:0]  out_data_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spike_accumulator #(.INP_WIDTH(8), .OUT_WIDTH(12), .NUM_IN(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_spike(in_spike), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_sat(out_sat_a)
  );

  spike_accumulator #(.INP_WIDTH(8), .OUT_WIDTH(9), .NUM_IN(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_spike(in_spike), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_sat(out_sat_b)
  );

  // Reference: running sum in plain integers, f() applied after every beat.
  function automatic int f_model(input int s, input int w, inout bit c);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    int m;
`ifdef SPIKE_ACC_SATURATE_EN
    if (s > hi) begin c = 1'b1; return hi; end
    if (s < lo) begin c = 1'b1; return lo; end
    return s;
`else
    m = s & ((1 << w) - 1);
    if (m > hi) m -= (1 << w);
    return m;
`endif
  endfunction

  function automatic void model_frame(input int d[4], input bit s[4], input int w,
                                      output int sum, output bit sat);
    sum = 0;
    sat = 1'b0;
    for (int i = 0; i < 4; i++) sum = f_model(sum + (s[i] ? d[i] : 0), w, sat);
  endfunction

  // Drives four accepted beats; returns at #1 after the edge taking the last one.
  task automatic drive_frame(input int d[4], input bit s[4], input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = d[i][7:0];
      in_spike = s[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int d[4] = '{10, 20, 30, 40};
    bit s[4] = '{1, 1, 1, 1};
    drive_frame(d, s, 1'b0);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid_a, out_valid_b, out_sat_a, out_sat_b} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got va=%b vb=%b sa=%b sb=%b want all 0",
               out_valid_a, out_valid_b, out_sat_a, out_sat_b);
    end
    vectors++;
    if (out_data_a !== 12'sd0 || out_data_b !== 9'sd0) begin
      miscompares++;
      $display("FAIL reset_data got %0d/%0d want 0/0", out_data_a, out_data_b);
    end
    vectors++;
    if ({in_ready_a, in_ready_b} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_in_ready_held got %b%b want 00", in_ready_a, in_ready_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    vectors++;
    if ({in_ready_a, in_ready_b} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_release_in_ready got %b%b want 11", in_ready_a, in_ready_b);
    end
    @(posedge clk); #1;
  endtask

  // Runs one frame and compares both instances against the model.
  task automatic test_frame(input string name, input int d[4], input bit s[4],
                            input bit gaps);
    int  e_a, e_b;
    bit  s_a, s_b;
    model_frame(d, s, 12, e_a, s_a);
    model_frame(d, s, 9, e_b, s_b);
    drive_frame(d, s, gaps);
    vectors++;
    if ({out_valid_a, out_valid_b, in_ready_a, in_ready_b, out_sat_a, out_sat_b}
        !== {4'b1100, s_a, s_b}) begin
      miscompares++;
      $display("FAIL %s flags got v=%b%b r=%b%b sat=%b%b want v=11 r=00 sat=%b%b", name,
               out_valid_a, out_valid_b, in_ready_a, in_ready_b, out_sat_a, out_sat_b,
               s_a, s_b);
    end
    vectors++;
    if (out_data_a !== e_a[11:0]) begin
      miscompares++;
      $display("FAIL %s data12 got %0d want %0d", name, out_data_a, e_a);
    end
    vectors++;
    if (out_data_b !== e_b[8:0]) begin
      miscompares++;
      $display("FAIL %s data9 got %0d want %0d", name, out_data_b, e_b);
    end
    release_result();
    vectors++;
    if ({in_ready_a, in_ready_b, out_valid_a, out_valid_b} !== 4'b1100) begin
      miscompares++;
      $display("FAIL %s release got r=%b%b v=%b%b want r=11 v=00", name,
               in_ready_a, in_ready_b, out_valid_a, out_valid_b);
    end
  endtask

  task automatic test_plain_sum();
    test_frame("plain_sum", '{10, -3, 127, -128}, '{1, 1, 1, 1}, 1'b0);
  endtask

  task automatic test_spike_gating();
    int d[4] = '{100, 100, 100, 100};
    bit s[4] = '{1, 0, 1, 0};
    // Three beats must not complete the frame.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = d[i][7:0]; in_spike = s[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++;
    if ({out_valid_a, out_valid_b} !== 2'b00) begin
      miscompares++;
      $display("FAIL gating_early_valid got %b%b want 00", out_valid_a, out_valid_b);
    end
    in_valid = 1'b1; in_data = d[3][7:0]; in_spike = s[3];
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if ({out_valid_a, out_valid_b} !== 2'b11 || out_data_a !== 12'sd200
        || out_data_b !== 9'sd200) begin
      miscompares++;
      $display("FAIL gating_sum got v=%b%b %0d/%0d want v=11 200/200",
               out_valid_a, out_valid_b, out_data_a, out_data_b);
    end
    release_result();
  endtask

  task automatic test_saturation();
    test_frame("sat_pos", '{127, 127, 127, 127}, '{1, 1, 1, 1}, 1'b0);
    test_frame("sat_neg", '{-128, -128, -128, -128}, '{1, 1, 1, 1}, 1'b0);
  endtask

  task automatic test_backpressure();
    int d[4] = '{-7, 33, 5, 12};
    bit s[4] = '{1, 1, 1, 1};
    int n[4] = '{3, 4, 5, 6};
    int e_a, e_b;
    bit s_a, s_b;
    logic signed [11:0] held;
    drive_frame(d, s, 1'b0);
    held = out_data_a;
    in_valid = 1'b1; in_data = 8'd77; in_spike = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_data_a !== held || {in_ready_a, in_ready_b, out_valid_a, out_valid_b}
          !== 4'b0011) begin
        miscompares++;
        $display("FAIL backpressure_hold cyc %0d got %0d r=%b%b v=%b%b want %0d r=00 v=11",
                 c, out_data_a, in_ready_a, in_ready_b, out_valid_a, out_valid_b, held);
      end
    end
    in_valid = 1'b0;
    release_result();
    model_frame(n, s, 12, e_a, s_a);
    model_frame(n, s, 9, e_b, s_b);
    drive_frame(n, s, 1'b0);
    vectors++;
    if (out_data_a !== e_a[11:0] || out_data_b !== e_b[8:0] || out_valid_a !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_next got %0d/%0d v=%b want %0d/%0d v=1",
               out_data_a, out_data_b, out_valid_a, e_a, e_b);
    end
    release_result();
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'd50; in_spike = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    test_frame("reset_mid_frame", '{1, 1, 1, 1}, '{1, 1, 1, 1}, 1'b0);
  endtask

  task automatic test_random();
    int d[4];
    bit s[4];
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 4; i++) begin
        d[i] = int'($urandom_range(0, 255)) - 128;
        s[i] = 1'($urandom_range(0, 1));
      end
      test_frame("random", d, s, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_spike = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_plain_sum();
    test_spike_gating();
    test_saturation();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spike_accumulator.md
# spike_accumulator

Parametrised, sequential successor to the combinational two-input signed adder in the spiking layers. Accumulates a frame of `NUM_IN` signed synaptic weights, each gated by a per-beat spike bit, into one `OUT_WIDTH`-bit signed sum. The sum is the membrane-potential increment for one neuron per time step. Sits between the synapse weight fetch and the neuron membrane/threshold logic, with valid/ready on both sides.

## Interface
- `INP_WIDTH`, 8: signed weight width.
- `OUT_WIDTH`, 12: signed accumulator and result width. Must be ≥ `INP_WIDTH+1`.
- `NUM_IN`, 16: beats per frame. Must be ≥ 2. Counter width is `$clog2(NUM_IN)`.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: an input beat is present.
- `in_ready` out 1: the block can accept a beat.
- `in_data` in `INP_WIDTH`: signed weight.
- `in_spike` in 1: 1 = add `in_data`; 0 = add zero. The beat is still counted.
- `out_valid` out 1: a frame result is pending.
- `out_ready` in 1: the consumer accepts the result.
- `out_data` out `OUT_WIDTH`: signed frame sum.
- `out_sat` out 1: at least one clamp occurred in this frame.

## Operation
- Two states:
  - `ACC`: `in_ready`=1, `out_valid`=0.
  - `OUT`: `in_ready`=0, `out_valid`=1.
- Beat accept condition: `in_valid && in_ready`.
- On each accepted beat:
  - addend = `in_spike ? sext(in_data) : 0`.
  - `acc <= f(acc + addend)`, with the sum computed at `OUT_WIDTH+1` bits.
  - `cnt` increments.
- The clamp is applied per beat, so a sequence that overflows and comes back still ends at the clamped running value.
- On the accept where `cnt == NUM_IN-1`:
  - `out_data <= f(acc + addend)` and `out_sat` <= sticky flag OR this beat's clamp.
  - `acc`, `cnt` and the sticky flag clear.
  - State goes to `OUT`.
- In `OUT`: `out_data` and `out_sat` hold stable. `in_valid` is ignored; no beat is consumed.
- On `out_valid && out_ready`: state goes to `ACC` in the next cycle.
- Reset (`rst`=1) forces:
  - `ACC` state.
  - `acc`=0, `cnt`=0, sticky flag=0.
  - `out_data`=0, `out_sat`=0, `out_valid`=0.
  - `in_ready`=1 once `rst` deasserts. `in_ready` is also held at 0 while `rst` is high.
- Reset mid-frame discards the partial sum. Reset while in `OUT` drops the pending result.

## Timing
- Latency: `out_valid` rises the cycle after the final accepted beat.
- Throughput: `NUM_IN` beats per frame, plus at least one `OUT` cycle per frame (the handshake cycle).
- `in_ready` deasserts in the same cycle `out_valid` asserts. No beat can be accepted while a result is pending.
- `in_ready` and `out_valid` are registered state decodes with no combinational path from `out_ready`.
- Full backpressure: `out_ready`=0 holds `OUT` indefinitely with no change in any output.

## Configuration
- `SPIKE_ACC_SATURATE_EN` defined:
  - f() clamps to [-2^(`OUT_WIDTH`-1), 2^(`OUT_WIDTH`-1)-1].
  - `out_sat` is functional.
- Not defined:
  - f() is two's-complement wrap, i.e. truncation to `OUT_WIDTH` bits.
  - `out_sat` is tied to 0.

## Structure
- Shared package `snn_pkg`: the state typedef (`ACC`, `OUT`) and the sat-min/sat-max constant functions of width.
- One sub-module, `sat_add`: a combinational `OUT_WIDTH` signed add of accumulator and extended addend. It returns the result and a clamp flag, and its saturation logic is compiled out under the macro.
- Counter, FSM and output registers live in `spike_accumulator`.

## Test plan
1. Reset test (`OUT_WIDTH`=12, `NUM_IN`=4):
   - Stimulus: assert `rst` mid-cycle (async).
   - Required: `out_valid`=0, `out_data`=0, `out_sat`=0 immediately; `in_ready`=1 after release.
2. Plain sum (`OUT_WIDTH`=12, `NUM_IN`=4):
   - Stimulus: 4 beats, all `in_spike`=1, data 10, -3, 127, -128.
   - Required: one cycle after beat 4, `out_valid`=1, `out_data`=6, `out_sat`=0.
3. Spike gating (`OUT_WIDTH`=12, `NUM_IN`=4):
   - Stimulus: data 100 ×4 with spikes 1, 0, 1, 0.
   - Required: `out_data`=200, and the frame still completes after 4 beats.
4. Saturation (`OUT_WIDTH`=9, `NUM_IN`=4):
   - 127 ×4: macro on → 255, `out_sat`=1; macro off → -4.
   - -128 ×4: macro on → -256, `out_sat`=1; macro off → 0.
5. Backpressure:
   - Stimulus: hold `out_ready`=0 for 5 cycles with `in_valid`=1.
   - Required: `out_data` stable, `in_ready`=0, no beats counted. After `out_ready`=1, the next cycle shows `in_ready`=1 and the next frame sums only new beats.
6. Reset mid-frame:
   - Stimulus: accept beats 50, 50; pulse `rst`; then a full frame of 1, 1, 1, 1.
   - Required: `out_data`=4.
